// File: rtl/lock_entry_ctrl.sv
// Entry sequencer for the 4-digit pattern lock core: qualifies presses, issues step
// strobes, tracks failures, times lockout and unlock hold. Define LOCK_IDLE_TIMEOUT_EN
// to add the inactivity timeout that clears a partially entered code.
module lock_entry_ctrl #(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned MAX_FAILS  = 3,
  parameter int unsigned LOCK_CYC   = 1000,
  parameter int unsigned HOLD_CYC   = 50,
  parameter int unsigned LAST_IDX   = 3,
  parameter int unsigned IDLE_CYC   = 5000,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enter,
  input  logic [3:0]                     in_pattern,
  input  logic [3:0]                     core_state,
  input  logic                           core_pass,
  input  logic                           core_fail,
  output logic                           step_en,
  output logic [3:0]                     pattern_out,
  output logic                           core_rst,
  output logic                           unlocked,
  output logic                           lockout,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
  output logic                           timeout
);

  localparam int unsigned FW = $clog2(MAX_FAILS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_STEP,
    S_WAIT_REL,
    S_UNLOCK,
    S_LOCKOUT
  } state_t;

  state_t         state_q;
  logic           enter_q;
  logic [CNT_W-1:0] cnt_q;
  logic           step_en_q;
  logic [3:0]     pattern_q;
  logic           core_rst_q;
  logic           unlocked_q;
  logic           lockout_q;
  logic [FW-1:0]  fail_cnt_q;
  logic [FW-1:0]  fail_cnt_d;
  logic           rise;
  logic           pass_ok;

  assign rise    = enter & ~enter_q;
  // Both or neither indication high is treated as a failed step.
  assign pass_ok = core_pass & ~core_fail;
  assign fail_cnt_d = (fail_cnt_q == FW'(MAX_FAILS)) ? fail_cnt_q : fail_cnt_q + FW'(1);

`ifdef LOCK_IDLE_TIMEOUT_EN
  logic [CNT_W-1:0] idle_cnt_q;
  logic             timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      enter_q    <= 1'b0;
      cnt_q      <= '0;
      step_en_q  <= 1'b0;
      pattern_q  <= '0;
      core_rst_q <= 1'b0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      fail_cnt_q <= '0;
`ifdef LOCK_IDLE_TIMEOUT_EN
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      enter_q    <= enter;
      step_en_q  <= 1'b0;
      core_rst_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            pattern_q <= in_pattern;
            cnt_q     <= '0;
            state_q   <= S_QUAL;
          end
        end
        S_QUAL: begin
          if (!enter) begin
            state_q <= S_IDLE;
          end else if (in_pattern != pattern_q) begin
            pattern_q <= in_pattern;
            cnt_q     <= '0;
          end else if (cnt_q == CNT_W'(STABLE_CYC - 1)) begin
            step_en_q <= 1'b1;
            state_q   <= S_STEP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STEP: begin
          cnt_q <= '0;
          if (pass_ok && (core_state == 4'(LAST_IDX))) begin
            fail_cnt_q <= '0;
            unlocked_q <= 1'b1;
            core_rst_q <= (HOLD_CYC == 1);
            state_q    <= S_UNLOCK;
          end else if (pass_ok) begin
            state_q <= S_WAIT_REL;
          end else begin
            fail_cnt_q <= fail_cnt_d;
            if (fail_cnt_d == FW'(MAX_FAILS)) begin
              lockout_q  <= 1'b1;
              core_rst_q <= 1'b1;
              state_q    <= S_LOCKOUT;
            end else begin
              state_q <= S_WAIT_REL;
            end
          end
        end
        S_WAIT_REL: begin
          if (!enter) state_q <= S_IDLE;
        end
        S_UNLOCK: begin
          // Core clear lands in the final hold cycle.
          if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
            unlocked_q <= 1'b0;
            state_q    <= S_WAIT_REL;
          end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            core_rst_q <= ((cnt_q + CNT_W'(1)) == CNT_W'(HOLD_CYC - 1));
          end
        end
        S_LOCKOUT: begin
          if (cnt_q == CNT_W'(LOCK_CYC - 1)) begin
            lockout_q  <= 1'b0;
            fail_cnt_q <= '0;
            state_q    <= S_WAIT_REL;
          end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            core_rst_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef LOCK_IDLE_TIMEOUT_EN
      // Inactivity with a partially advanced core clears it.
      timeout_q <= 1'b0;
      if (state_q == S_STEP) begin
        idle_cnt_q <= '0;
      end else if (((state_q == S_IDLE) || (state_q == S_WAIT_REL)) && (core_state != 4'd0)) begin
        if (idle_cnt_q == CNT_W'(IDLE_CYC - 1)) begin
          idle_cnt_q <= '0;
          timeout_q  <= 1'b1;
          core_rst_q <= 1'b1;
        end else begin
          idle_cnt_q <= idle_cnt_q + CNT_W'(1);
        end
      end
`endif
    end
  end

  assign step_en     = step_en_q;
  assign pattern_out = pattern_q;
  assign core_rst    = core_rst_q;
  assign unlocked    = unlocked_q;
  assign lockout     = lockout_q;
  assign fail_cnt    = fail_cnt_q;
`ifdef LOCK_IDLE_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_lock_entry_ctrl.sv
// Bench for lock_entry_ctrl: vector table, directed lockout/unlock/timeout
// sequences and randomized traffic against a countdown-based reference model.
module tb_lock_entry_ctrl;

  localparam int unsigned STABLE = 2;
  localparam int unsigned MAXF   = 2;
  localparam int unsigned LOCKC  = 8;
  localparam int unsigned HOLDC  = 4;
  localparam int unsigned LAST   = 3;
  localparam int unsigned IDLEC  = 16;

  logic       clk;
  logic       rst;
  logic       enter;
  logic [3:0] in_pattern;
  logic [3:0] core_state;
  logic       core_pass;
  logic       core_fail;
  logic       step_en;
  logic [3:0] pattern_out;
  logic       core_rst;
  logic       unlocked;
  logic       lockout;
  logic [1:0] fail_cnt;
  logic       timeout;

  lock_entry_ctrl #(
    .STABLE_CYC(STABLE), .MAX_FAILS(MAXF), .LOCK_CYC(LOCKC), .HOLD_CYC(HOLDC),
    .LAST_IDX(LAST), .IDLE_CYC(IDLEC), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .enter(enter), .in_pattern(in_pattern),
    .core_state(core_state), .core_pass(core_pass), .core_fail(core_fail),
    .step_en(step_en), .pattern_out(pattern_out), .core_rst(core_rst),
    .unlocked(unlocked), .lockout(lockout), .fail_cnt(fail_cnt), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases tracked as flags and countdowns, qualification by timestamp.
  int unsigned now_c = 0;
  bit          m_step, m_crst, m_unl, m_lock, m_to, m_qual, m_rel, m_eprev;
  logic [3:0]  m_po;
  int          m_fails, m_load_t, m_hold_left, m_lock_left, m_idle_run;

  task automatic model_update();
    bit idle_like;
    bit was_step;
    now_c++;
    if (rst) begin
      {m_step, m_crst, m_unl, m_lock, m_to, m_qual, m_rel, m_eprev} = '0;
      m_po = 4'h0;
      m_fails = 0; m_load_t = 0; m_hold_left = 0; m_lock_left = 0; m_idle_run = 0;
      return;
    end
    idle_like = !m_qual && !m_step && (m_hold_left == 0) && (m_lock_left == 0);
    was_step  = m_step;
    m_step = 1'b0; m_crst = 1'b0; m_to = 1'b0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) begin m_lock = 1'b0; m_fails = 0; m_rel = 1'b1; end
      else m_crst = 1'b1;
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin m_unl = 1'b0; m_rel = 1'b1; end
      else m_crst = (m_hold_left == 1);
    end else if (was_step) begin
      if (core_pass && !core_fail) begin
        if (core_state == 4'(LAST)) begin
          m_fails = 0; m_hold_left = HOLDC; m_unl = 1'b1; m_crst = (HOLDC == 1);
        end else m_rel = 1'b1;
      end else begin
        if (m_fails < int'(MAXF)) m_fails++;
        if (m_fails == int'(MAXF)) begin m_lock_left = LOCKC; m_lock = 1'b1; m_crst = 1'b1; end
        else m_rel = 1'b1;
      end
    end else if (m_qual) begin
      if (!enter) m_qual = 1'b0;
      else if (in_pattern != m_po) begin m_po = in_pattern; m_load_t = int'(now_c); end
      else if (int'(now_c) - m_load_t == int'(STABLE)) begin m_qual = 1'b0; m_step = 1'b1; end
    end else if (m_rel) begin
      if (!enter) m_rel = 1'b0;
    end else if (enter && !m_eprev) begin
      m_qual = 1'b1; m_po = in_pattern; m_load_t = int'(now_c);
    end
`ifdef LOCK_IDLE_TIMEOUT_EN
    if (was_step) m_idle_run = 0;
    else if (idle_like && (core_state != 4'd0)) begin
      m_idle_run++;
      if (m_idle_run == int'(IDLEC)) begin m_idle_run = 0; m_to = 1'b1; m_crst = 1'b1; end
    end
`else
    if (idle_like) m_idle_run = 0;
`endif
    m_eprev = enter;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("model", 32'({step_en, pattern_out, fail_cnt, lockout, unlocked, core_rst, timeout}),
        32'({m_step, m_po, 2'(m_fails), m_lock, m_unl, m_crst, m_to}));
  endtask

  task automatic wait_step(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (step_en) seen = 1'b1;
    end
  endtask

  typedef struct packed {
    logic       rst, en;
    logic [3:0] pat, cs;
    logic       ps, fl;
    logic       step;
    logic [3:0] po;
    logic [1:0] fc;
    logic       lk, un, cr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] p, input logic [3:0] c,
                              input logic ps, input logic fl, input logic st, input logic [3:0] po,
                              input logic [1:0] fc);
    mk = '{rst: r, en: e, pat: p, cs: c, ps: ps, fl: fl, step: st, po: po, fc: fc,
           lk: 1'b0, un: 1'b0, cr: 1'b0};
  endfunction

  vec_t tbl[16];

  initial begin
    bit seen;
    int n, nc, st, at;
    rst = 1'b1; enter = 1'b0; in_pattern = 4'h0; core_state = 4'h0;
    core_pass = 1'b0; core_fail = 1'b0;

    // Reset, single press, held enter, pattern change mid-qualification, one failure.
    tbl[0]  = mk(1, 0, 4'h1, 4'h0, 0, 0, 0, 4'h0, 2'd0);
    tbl[1]  = mk(1, 1, 4'h1, 4'h0, 0, 0, 0, 4'h0, 2'd0);
    tbl[2]  = mk(0, 0, 4'h1, 4'h0, 0, 0, 0, 4'h0, 2'd0);
    tbl[3]  = mk(0, 1, 4'h1, 4'h0, 0, 0, 0, 4'h1, 2'd0);
    tbl[4]  = mk(0, 1, 4'h1, 4'h0, 0, 0, 0, 4'h1, 2'd0);
    tbl[5]  = mk(0, 1, 4'h1, 4'h0, 0, 0, 1, 4'h1, 2'd0);
    tbl[6]  = mk(0, 1, 4'h1, 4'h0, 1, 0, 0, 4'h1, 2'd0);
    tbl[7]  = mk(0, 1, 4'h1, 4'h0, 0, 0, 0, 4'h1, 2'd0);
    tbl[8]  = mk(0, 1, 4'h1, 4'h0, 0, 0, 0, 4'h1, 2'd0);
    tbl[9]  = mk(0, 0, 4'h1, 4'h0, 0, 0, 0, 4'h1, 2'd0);
    tbl[10] = mk(0, 1, 4'h1, 4'h0, 0, 0, 0, 4'h1, 2'd0);
    tbl[11] = mk(0, 1, 4'h2, 4'h0, 0, 0, 0, 4'h2, 2'd0);
    tbl[12] = mk(0, 1, 4'h2, 4'h0, 0, 0, 0, 4'h2, 2'd0);
    tbl[13] = mk(0, 1, 4'h2, 4'h0, 0, 0, 1, 4'h2, 2'd0);
    tbl[14] = mk(0, 1, 4'h2, 4'h1, 0, 1, 0, 4'h2, 2'd1);
    tbl[15] = mk(0, 0, 4'h2, 4'h0, 0, 0, 0, 4'h2, 2'd1);

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; enter = tbl[i].en; in_pattern = tbl[i].pat; core_state = tbl[i].cs;
      core_pass = tbl[i].ps; core_fail = tbl[i].fl;
      tick();
      chk($sformatf("vec%0d", i),
          32'({step_en, pattern_out, fail_cnt, lockout, unlocked, core_rst}),
          32'({tbl[i].step, tbl[i].po, tbl[i].fc, tbl[i].lk, tbl[i].un, tbl[i].cr}));
    end

    // Second failure: lockout and core clear for exactly LOCKC cycles, presses ignored.
    core_state = 4'h1; core_pass = 1'b0; core_fail = 1'b1; in_pattern = 4'h3; enter = 1'b1;
    wait_step(seen);
    chk("lock_step_seen", 32'(seen), 32'd1);
    tick();
    chk("lock_fail_cnt", 32'(fail_cnt), 32'd2);
    chk("lock_entered", 32'(lockout), 32'd1);
    n = 0; nc = 0; st = 0;
    while (lockout && n < 20) begin
      n++;
      if (core_rst) nc++;
      enter = ~enter;
      tick();
      if (step_en) st++;
    end
    chk("lock_len", 32'(n), 32'(LOCKC));
    chk("lock_crst_len", 32'(nc), 32'(LOCKC));
    chk("lock_no_step", 32'(st), 32'd0);
    chk("lock_fail_clr", 32'(fail_cnt), 32'd0);
    enter = 1'b0; tick(); tick();

    // One failure, then a passing last step: unlock hold with core clear in its last cycle.
    core_state = 4'h0; in_pattern = 4'h4; enter = 1'b1;
    wait_step(seen);
    chk("fail1_step_seen", 32'(seen), 32'd1);
    tick();
    chk("fail1_cnt", 32'(fail_cnt), 32'd1);
    enter = 1'b0; tick(); tick();
    core_state = 4'h3; core_pass = 1'b1; core_fail = 1'b0; in_pattern = 4'h5; enter = 1'b1;
    wait_step(seen);
    chk("unl_step_seen", 32'(seen), 32'd1);
    tick();
    chk("unl_entered", 32'(unlocked), 32'd1);
    chk("unl_fail_clr", 32'(fail_cnt), 32'd0);
    n = 0; nc = 0; at = -1;
    while (unlocked && n < 20) begin
      if (core_rst) begin nc++; at = n; end
      n++;
      tick();
    end
    chk("unl_len", 32'(n), 32'(HOLDC));
    chk("unl_crst_cnt", 32'(nc), 32'd1);
    chk("unl_crst_pos", 32'(at), 32'(HOLDC - 1));
    enter = 1'b0; core_pass = 1'b0; tick();

    // Inactivity with a partially advanced core.
    core_state = 4'h2;
    nc = 0; n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (timeout) begin
        nc++;
        n = n + int'(core_rst);
      end
    end
`ifdef LOCK_IDLE_TIMEOUT_EN
    chk("idle_timeout_cnt", 32'(nc), 32'd2);
    chk("idle_timeout_crst", 32'(n), 32'd2);
`else
    chk("idle_timeout_cnt", 32'(nc), 32'd0);
`endif

    // Randomized traffic including occasional mid-operation reset.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 4) == 0) enter = ~enter;
      if ($urandom_range(0, 7) == 0) in_pattern = 4'($urandom_range(0, 3));
      core_state = 4'($urandom_range(0, 4));
      {core_pass, core_fail} = 2'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b1; tick();
    chk("final_reset", 32'({step_en, pattern_out, fail_cnt, lockout, unlocked, core_rst, timeout}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
